intlv_sched: RTL and testbench

- Scheduler that shares one turbo-interleaver index generator between two input ping-pong banks (requesters 0/1).
- Arbitrates round-robin between the banks, latches the block size (K=1056 or K=6144), pulses the generator's ready input and tracks its index stream.
- Flags index validity and the last index, and returns a per-bank done pulse aligned with the generator's two-cycle completion tail.
- Sits between the input bank controllers and the index generator / interleaver memory address path.

---
 rtl/intlv_sched_pkg.sv | 25 ++
 rtl/intlv_rr_arb2.sv | 37 +++
 rtl/intlv_sched.sv | 161 ++++++++++++++++
 tb/tb_intlv_sched.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/intlv_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : intlv_sched_pkg
//  Purpose  : Shared types and constants for the interleaver index scheduler.
//  Revision : 1.0  initial release
// ============================================================================
package intlv_sched_pkg;

    localparam int c_idx_w   = 14;
    localparam int c_k_small = 1056;
    localparam int c_k_large = 6144;

    localparam logic [c_idx_w-1:0] c_last_small = 14'd1055;
    localparam logic [c_idx_w-1:0] c_last_large = 14'd6143;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        RUN    = 3'd2,
        DRAIN1 = 3'd3,
        DRAIN2 = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/intlv_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module   : intlv_rr_arb2
//  Purpose  : Two-way round-robin arbiter with a one-hot combinational grant.
//  Revision : 1.0  initial release
// ============================================================================
module intlv_rr_arb2 (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    // Remembers whether bank 1 won last; reset value makes bank 0 the favourite.
    logic r_last_b1;

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = r_last_b1 ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_last_b1 <= 1'b1;
        end else if (advance && (|grant)) begin
            r_last_b1 <= grant[1];
        end
    end

endmodule
`default_nettype wire

// File: rtl/intlv_sched.sv
`default_nettype none
// ============================================================================
//  Module   : intlv_sched
//  Purpose  : Shares one turbo-interleaver index generator between two banks.
//             Optional RUN watchdog enabled by macro INTLV_SCHED_WDOG_EN.
//  Revision : 1.0  initial release
// ============================================================================
module intlv_sched
    import intlv_sched_pkg::*;
#(
    parameter int IDX_W   = c_idx_w,
    parameter int K_SMALL = c_k_small,
    parameter int K_LARGE = c_k_large
`ifdef INTLV_SCHED_WDOG_EN
    ,parameter int WDOG_CYC = 6160
`endif
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       req,
    input  logic [1:0]       req_k,
    output logic [1:0]       grant,
    output logic             gen_ready,
    output logic             gen_k,
    input  logic [IDX_W-1:0] gen_idx,
    input  logic             gen_kout,
    output logic [IDX_W-1:0] idx_out,
    output logic             idx_valid,
    output logic             idx_last,
    output logic [1:0]       done,
    output logic             busy,
    output logic             k_err
`ifdef INTLV_SCHED_WDOG_EN
    ,output logic            wdog_err
`endif
);

    localparam logic [IDX_W-1:0] c_lim_small = IDX_W'(K_SMALL - 1);
    localparam logic [IDX_W-1:0] c_lim_large = IDX_W'(K_LARGE - 1);

    state_t           r_state;
    logic [1:0]       r_grant;
    logic             r_gen_ready;
    logic             r_gen_k;
    logic             r_idx_valid;
    logic [1:0]       r_done;
    logic             r_busy;
    logic             r_k_err;

    logic [1:0]       w_arb_grant;
    logic             w_arb_adv;
    logic             w_win_k;
    logic [IDX_W-1:0] w_last;
    logic             w_at_last;
    logic             w_wdog_hit;

    assign w_arb_adv = (r_state == IDLE) && (|req);
    assign w_win_k   = w_arb_grant[1] ? req_k[1] : req_k[0];
    assign w_last    = r_gen_k ? c_lim_large : c_lim_small;
    assign w_at_last = (gen_idx == w_last);

    intlv_rr_arb2 u_arb (
        .clock   (clock),
        .reset   (reset),
        .req     (req),
        .advance (w_arb_adv),
        .grant   (w_arb_grant)
    );

`ifdef INTLV_SCHED_WDOG_EN
    localparam int c_wd_w = $clog2(WDOG_CYC + 1);

    // Counter holds (RUN cycle number - 1), so the hit fires on RUN cycle WDOG_CYC.
    logic [c_wd_w-1:0] r_run_cnt;
    logic              r_wdog_err;

    assign w_wdog_hit = (r_state == RUN) && (r_run_cnt == c_wd_w'(WDOG_CYC - 1));
    assign wdog_err   = r_wdog_err;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_run_cnt  <= '0;
            r_wdog_err <= 1'b0;
        end else begin
            if (r_state == START) begin
                r_run_cnt <= '0;
            end else if (r_state == RUN) begin
                r_run_cnt <= r_run_cnt + 1'b1;
            end
            if (w_wdog_hit && !w_at_last) begin
                r_wdog_err <= 1'b1;
            end
        end
    end
`else
    assign w_wdog_hit = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_grant     <= 2'b00;
            r_gen_ready <= 1'b0;
            r_gen_k     <= 1'b0;
            r_idx_valid <= 1'b0;
            r_done      <= 2'b00;
            r_busy      <= 1'b0;
            r_k_err     <= 1'b0;
        end else begin
            r_gen_ready <= 1'b0;
            r_done      <= 2'b00;
            if ((r_state == RUN) && (gen_kout != r_gen_k)) begin
                r_k_err <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (|req) begin
                        r_grant     <= w_arb_grant;
                        r_gen_k     <= w_win_k;
                        r_gen_ready <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= START;
                    end
                end
                START: begin
                    r_idx_valid <= 1'b1;
                    r_state     <= RUN;
                end
                RUN: begin
                    if (w_at_last || w_wdog_hit) begin
                        r_idx_valid <= 1'b0;
                        r_state     <= DRAIN1;
                    end
                end
                DRAIN1: begin
                    // done is registered here so it appears during DRAIN2.
                    r_done  <= r_grant;
                    r_state <= DRAIN2;
                end
                DRAIN2: begin
                    r_grant <= 2'b00;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign grant     = r_grant;
    assign gen_ready = r_gen_ready;
    assign gen_k     = r_gen_k;
    assign idx_out   = gen_idx;
    assign idx_valid = r_idx_valid;
    assign idx_last  = r_idx_valid & w_at_last;
    assign done      = r_done;
    assign busy      = r_busy;
    assign k_err     = r_k_err;

endmodule
`default_nettype wire

// File: tb/tb_intlv_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_intlv_sched
//  Purpose  : Directed self-checking bench for intlv_sched with a generator model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_intlv_sched;

    localparam int IDX_W = 14;
    localparam int TB_WDOG = 6160;

    logic             clock;
    logic             reset;
    logic [1:0]       req;
    logic [1:0]       req_k;
    logic [1:0]       grant;
    logic             gen_ready;
    logic             gen_k;
    logic [IDX_W-1:0] gen_idx;
    logic             gen_kout;
    logic [IDX_W-1:0] idx_out;
    logic             idx_valid;
    logic             idx_last;
    logic [1:0]       done;
    logic             busy;
    logic             k_err;
`ifdef INTLV_SCHED_WDOG_EN
    logic             wdog_err;
`endif

    int tests = 0;
    int fails = 0;

    // Generator model state
    logic g_run;
    logic gk;
    logic stall;
    logic kforce;

    // Results of the most recent watch()
    int nvalid, nlast, nbusy, ndone, nready, seq_bad, gchg;
    int last_val, last_cyc, done_cyc;
    logic [1:0] done_val;

    intlv_sched #(
        .IDX_W   (IDX_W),
        .K_SMALL (1056),
        .K_LARGE (6144)
`ifdef INTLV_SCHED_WDOG_EN
        ,.WDOG_CYC (TB_WDOG)
`endif
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .req_k     (req_k),
        .grant     (grant),
        .gen_ready (gen_ready),
        .gen_k     (gen_k),
        .gen_idx   (gen_idx),
        .gen_kout  (gen_kout),
        .idx_out   (idx_out),
        .idx_valid (idx_valid),
        .idx_last  (idx_last),
        .done      (done),
        .busy      (busy),
        .k_err     (k_err)
`ifdef INTLV_SCHED_WDOG_EN
        ,.wdog_err (wdog_err)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Index generator: index 0 on the cycle after gen_ready, then +1 per cycle up to last.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            g_run   <= 1'b0;
            gen_idx <= '0;
            gk      <= 1'b0;
        end else if (gen_ready) begin
            g_run   <= 1'b1;
            gen_idx <= '0;
            gk      <= gen_k;
        end else if (g_run) begin
            if (gen_idx == (gk ? 14'd6143 : 14'd1055))
                g_run <= 1'b0;
            else if (!stall)
                gen_idx <= gen_idx + 14'd1;
        end
    end

    assign gen_kout = kforce ? ~gk : gk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called at the START-cycle negedge; follows the block until busy drops.
    task automatic watch(input int budget, input bit drop);
        logic [1:0] g0;
        nvalid = 0; nlast = 0; nbusy = 0; ndone = 0; nready = 0; seq_bad = 0; gchg = 0;
        last_val = -1; last_cyc = -1; done_cyc = -1; done_val = 2'b00;
        g0 = grant;
        for (int cyc = 0; cyc < budget; cyc++) begin
            if (!busy) break;
            nbusy++;
            if (grant !== g0) gchg++;
            if (gen_ready) nready++;
            if (idx_valid) begin
                if (idx_out !== nvalid[IDX_W-1:0]) seq_bad++;
                nvalid++;
            end
            if (idx_last) begin
                nlast++;
                last_val = int'(idx_out);
                last_cyc = cyc;
            end
            if (done != 2'b00) begin
                ndone++;
                done_val = done;
                done_cyc = cyc;
                if (drop) req = 2'b00;
            end
            @(negedge clock);
        end
        chk("watch_end_busy", busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        reset = 1'b1; req = 2'b00; req_k = 2'b00; stall = 1'b0; kforce = 1'b0;
        repeat (2) @(negedge clock);
        chk("reset_outs", {grant, gen_ready, gen_k, idx_valid, idx_last, done, busy, k_err}, 0);
        reset = 1'b0;
        @(negedge clock);

        // Bank 0, small block
        req = 2'b01; req_k = 2'b00;
        @(negedge clock);
        chk("t1_grant", grant, 2'b01);
        chk("t1_ready", gen_ready, 1);
        chk("t1_valid_in_start", idx_valid, 0);
        watch(1200, 1);
        chk("t1_nvalid", nvalid, 1056);
        chk("t1_nlast", nlast, 1);
        chk("t1_last_idx", last_val, 1055);
        chk("t1_done_delay", done_cyc - last_cyc, 2);
        chk("t1_done", done_val, 2'b01);
        chk("t1_nbusy", nbusy, 1059);
        chk("t1_seq", seq_bad, 0);
        chk("t1_ready_width", nready, 1);
        chk("t1_grant_stable", gchg, 0);

        // Bank 1, large block; req and req_k dropped right after grant
        req = 2'b10; req_k = 2'b10;
        @(negedge clock);
        chk("t2_grant", grant, 2'b10);
        chk("t2_gen_k", gen_k, 1);
        req = 2'b00; req_k = 2'b00;
        watch(6300, 0);
        chk("t2_nvalid", nvalid, 6144);
        chk("t2_last_idx", last_val, 6143);
        chk("t2_nbusy", nbusy, 6147);
        chk("t2_done", done_val, 2'b10);
        chk("t2_ndone", ndone, 1);
        chk("t2_gen_k_held", nlast, 1);
        chk("t2_k_err_clear", k_err, 0);

        // Bank 0 again, then reset at index 500
        req = 2'b01;
        @(negedge clock);
        chk("t4_grant", grant, 2'b01);
        for (int i = 0; i < 1000; i++) begin
            if (idx_valid && (idx_out == 14'd500)) break;
            @(negedge clock);
        end
        chk("t4_at_500", {idx_valid, idx_out}, {1'b1, 14'd500});
        reset = 1'b1;
        #1;
        chk("t4_async_clear", {grant, gen_ready, gen_k, idx_valid, idx_last, done, busy, k_err}, 0);
        req = 2'b00;
        repeat (3) @(negedge clock);
        chk("t4_no_done", {done, busy}, 0);
        reset = 1'b0;
        req = 2'b11; req_k = 2'b00;
        @(negedge clock);
        chk("t4_post_reset_bank0", grant, 2'b01);

        // Both banks held: grants alternate
        watch(1200, 0);
        chk("t3_done_a", done_val, 2'b01);
        @(negedge clock);
        chk("t3_grant_b", grant, 2'b10);
        chk("t3_ready_b", gen_ready, 1);
        watch(1200, 0);
        chk("t3_done_b", done_val, 2'b10);
        @(negedge clock);
        chk("t3_grant_c", grant, 2'b01);
        watch(1200, 1);
        chk("t3_done_c", done_val, 2'b01);
        chk("t3_nvalid_c", nvalid, 1056);

        // k echo mismatch during RUN
        req = 2'b10; req_k = 2'b10;
        @(negedge clock);
        kforce = 1'b1;
        @(negedge clock);
        chk("t5_k_err_not_in_start", k_err, 0);
        @(negedge clock);
        chk("t5_k_err_set", k_err, 1);
        kforce = 1'b0;
        watch(6300, 1);
        chk("t5_done", done_val, 2'b10);
        chk("t5_k_err_sticky", k_err, 1);
        reset = 1'b1;
        @(negedge clock);
        chk("t5_k_err_reset", k_err, 0);
        reset = 1'b0;
        req_k = 2'b00;
        @(negedge clock);

`ifdef INTLV_SCHED_WDOG_EN
        begin
            int n;
            int nl;
            n = 0; nl = 0;
            req = 2'b01;
            @(negedge clock);
            chk("wd_err_clear", wdog_err, 0);
            for (int i = 0; i < TB_WDOG + 200; i++) begin
                @(negedge clock);
                if (!idx_valid) break;
                n++;
                if (idx_last) nl++;
                if (idx_out == 14'd7) stall = 1'b1;
            end
            chk("wd_run_len", n, TB_WDOG);
            chk("wd_no_last", nl, 0);
            chk("wd_err_set", wdog_err, 1);
            chk("wd_done_not_yet", done, 2'b00);
            @(negedge clock);
            chk("wd_done", done, 2'b01);
            req = 2'b00; stall = 1'b0;
            @(negedge clock);
            chk("wd_err_sticky", {wdog_err, busy}, 2'b10);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
